// File: rtl/payload_aligner.sv
// Strips a programmable header from a gap-free 32-bit frame stream and re-packs the payload
// big-endian. Defining PAYLOAD_ALIGNER_STATS_EN adds frame_cnt/err_cnt counters.
module payload_aligner #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [1:0]       in_bytes,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  input  logic [7:0]       hdr_len,
  output logic [31:0]      out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             out_clear,
  output logic             out_done,
  output logic [LEN_W-1:0] out_len,
  output logic             frame_err
`ifdef PAYLOAD_ALIGNER_STATS_EN
  ,
  output logic [31:0]      frame_cnt,
  output logic [15:0]      err_cnt
`endif
);
  // Handshake: a word transfers on a rising edge with in_valid && in_ready; in_ready is
  // low only while the spill word of a frame is flushed, and in_valid may not drop mid-frame.
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [7:0]       h_q, h_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [31:0]      hold_q, hold_d;
  logic [2:0]       rem_q, rem_d;
  logic [LEN_W-1:0] acc_q, acc_d;
  logic [31:0]      data_q, data_d;
  logic             valid_q, valid_d, last_q, last_d, clear_q, clear_d;
  logic             done_q, done_d, err_q, err_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic [1:0]  k;
  logic [5:0]  w_idx;
  logic [4:0]  sh;
  logic [2:0]  nb, hb, r;
  logic [31:0] comb;
  logic        start, abort;

  function automatic logic [31:0] keep_top(input logic [31:0] w, input logic [2:0] n);
    return w & ~(32'hFFFF_FFFF >> {n, 3'b000});
  endfunction

  function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a, input logic [2:0] n);
    logic [LEN_W:0] s;
    s = {1'b0, a} + {{(LEN_W-2){1'b0}}, n};
    return s[LEN_W] ? '1 : s[LEN_W-1:0];
  endfunction

  assign k        = h_q[1:0];
  assign w_idx    = h_q[7:2];
  assign sh       = {k, 3'b000};
  assign nb       = (in_bytes == 2'd0) ? 3'd4 : {1'b0, in_bytes};
  assign hb       = (k == 2'd0) ? 3'd0 : 3'd4 - {1'b0, k};
  assign r        = hb + nb;
  // Held tail of the previous word on top, head of the current word below it.
  assign comb     = (k == 2'd0) ? in_data
                  : ((hold_q << sh) | (in_data >> (6'd32 - {1'b0, sh})));
  assign in_ready = (state_q != S_FLUSH);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    data_d  = '0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    clear_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    len_d   = '0;
    start   = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: start = in_valid && in_sop;
      S_HDR, S_PAY: begin
        if (!in_valid || in_sop) begin
          abort = 1'b1;
          start = in_valid;
        end else if (state_q == S_HDR) begin
          if (cnt_q != w_idx) begin
            cnt_d = cnt_q + 6'd1;
            if (in_eop) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else if (in_eop) begin
            // Frame ends inside the first payload word: only bytes past offset k count.
            if (nb > {1'b0, k}) begin
              valid_d = 1'b1;
              last_d  = 1'b1;
              data_d  = keep_top(in_data << sh, nb - {1'b0, k});
              len_d   = {{(LEN_W-3){1'b0}}, nb - {1'b0, k}};
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            hold_d  = in_data;
            state_d = S_PAY;
            if (k == 2'd0) begin
              valid_d = 1'b1;
              data_d  = in_data;
              acc_d   = sat_add('0, 3'd4);
            end
          end
        end else begin
          hold_d = in_data;
          if (in_eop && r <= 3'd4) begin
            valid_d = 1'b1;
            last_d  = 1'b1;
            done_d  = 1'b1;
            data_d  = keep_top(comb, r);
            len_d   = sat_add(acc_q, r);
            state_d = S_IDLE;
          end else begin
            valid_d = 1'b1;
            data_d  = comb;
            acc_d   = sat_add(acc_q, 3'd4);
            if (in_eop) begin
              rem_d   = r - 3'd4;
              state_d = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        valid_d = 1'b1;
        last_d  = 1'b1;
        done_d  = 1'b1;
        data_d  = keep_top(hold_q << sh, rem_q);
        len_d   = sat_add(acc_q, rem_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      err_d   = 1'b1;
      clear_d = 1'b1;
      hold_d  = '0;
      acc_d   = '0;
      state_d = S_IDLE;
    end
    if (start) begin
      clear_d = 1'b1;
      h_d     = (hdr_len < 8'd4) ? 8'd4 : hdr_len;
      cnt_d   = 6'd1;
      hold_d  = '0;
      acc_d   = '0;
      if (in_eop) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        state_d = S_HDR;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      clear_q <= clear_d;
      done_q  <= done_d;
      err_q   <= err_d;
      len_q   <= len_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_clear = clear_q;
  assign out_done  = done_q;
  assign out_len   = len_q;
  assign frame_err = err_q;

`ifdef PAYLOAD_ALIGNER_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (done_d) frame_cnt_d = frame_cnt_q + 32'd1;
    if (err_d)  err_cnt_d   = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif
endmodule

// File: tb/tb_payload_aligner.sv
// Directed bench for payload_aligner: byte-level frame model plus hand-computed literal checks.
`timescale 1ns/1ps
module tb_payload_aligner;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             in_valid, in_sop, in_eop;
  logic [1:0]       in_bytes;
  logic [31:0]      in_data;
  logic             in_ready;
  logic [7:0]       hdr_len;
  logic [31:0]      out_data;
  logic             out_valid, out_last, out_clear, out_done;
  logic [LEN_W-1:0] out_len;
  logic             frame_err;
`ifdef PAYLOAD_ALIGNER_STATS_EN
  logic [31:0]      frame_cnt;
  logic [15:0]      err_cnt;
`endif

  payload_aligner #(.LEN_W(LEN_W)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_bytes(in_bytes), .in_data(in_data), .in_ready(in_ready), .hdr_len(hdr_len),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_clear(out_clear),
    .out_done(out_done), .out_len(out_len), .frame_err(frame_err)
`ifdef PAYLOAD_ALIGNER_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [32:0] exp_q[$];
  int          exp_len_q[$];
  logic [32:0] obs_q[$];
  int          obs_cyc_q[$];
  int          obs_len_q[$];
  int total = 0, bad = 0, cyc = 0;
  int clr_cnt = 0, err_seen = 0, done_cnt = 0, ready_low = 0, last_clear_cyc = -1;
  int sop_cyc = 0, eop_cyc = 0;
  int s_obs, s_len, s_done, s_clr, s_err, s_rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] obs_at(input int i);
    if (i < obs_q.size()) return obs_q[i];
    return 33'h1_FFFF_FFFF;
  endfunction

  function automatic int obs_cyc_at(input int i);
    if (i < obs_cyc_q.size()) return obs_cyc_q[i];
    return -1;
  endfunction

  function automatic int len_at(input int i);
    if (i < obs_len_q.size()) return obs_len_q[i];
    return -1;
  endfunction

  task automatic snap();
    s_obs = obs_q.size(); s_len = obs_len_q.size(); s_done = done_cnt;
    s_clr = clr_cnt; s_err = err_seen; s_rdy = ready_low;
  endtask

  // Model: payload = frame bytes from max(hdr,4) on, cut into big-endian words, zero-padded.
  // An aborted frame only yields the words whose last byte sits in an accepted input word.
  task automatic model_frame(input int hdr, input int nbytes, input int base, input int acc_words);
    int h, plen, nout;
    h    = (hdr < 4) ? 4 : hdr;
    plen = (nbytes > h) ? nbytes - h : 0;
    nout = (plen + 3) / 4;
    for (int j = 0; j < nout; j++) begin
      logic [31:0] w;
      int idx;
      if (acc_words >= 0 && ((h + 4 * j + 3) / 4) >= acc_words) break;
      for (int b = 0; b < 4; b++) begin
        idx = h + 4 * j + b;
        w[31 - 8 * b -: 8] = (idx < nbytes) ? 8'((base + idx) & 255) : 8'h00;
      end
      exp_q.push_back({(acc_words < 0 && j == nout - 1), w});
    end
    if (acc_words < 0) exp_len_q.push_back(plen);
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_bytes = 2'd0;
      in_data = 32'hDEAD_BEEF;
    end
  endtask

  // gap >= 0 drops in_valid for one cycle before word 'gap'; stop >= 0 presents only 'stop' words.
  task automatic send_frame(input int hdr, input int nbytes, input int base, input int gap,
                            input int stop);
    int nw, guard;
    nw = (nbytes + 3) / 4;
    model_frame(hdr, nbytes, base, (gap >= 0) ? gap : -1);
    for (int i = 0; i < nw; i++) begin
      if (stop >= 0 && i >= stop) break;
      if (i == gap) begin
        @(negedge clk);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_sop   = (i == 0);
      in_eop   = (i == nw - 1);
      in_bytes = (i == nw - 1) ? 2'(nbytes % 4) : 2'd0;
      hdr_len  = (i == 0) ? 8'(hdr) : 8'h00;
      for (int b = 0; b < 4; b++)
        in_data[31 - 8 * b -: 8] = (4 * i + b < nbytes) ? 8'((base + 4 * i + b) & 255) : 8'hEE;
      guard = 0;
      while (!in_ready && guard < 16) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 16) check("in_ready_timeout", 64'(in_ready), 64'd1);
      if (i == 0) sop_cyc = cyc;
      if (i == nw - 1) eop_cyc = cyc;
    end
  endtask

  // compare process
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (n_rst) begin
      if (out_valid) begin
        obs_q.push_back({out_last, out_data});
        obs_cyc_q.push_back(cyc);
        check("word_was_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check("out_word", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
      end else begin
        check("idle_out_zero", 64'({out_last, out_data}), 64'd0);
      end
      if (out_done) begin
        obs_len_q.push_back(int'(out_len));
        done_cnt++;
        check("done_was_expected", 64'(exp_len_q.size() > 0), 64'd1);
        if (exp_len_q.size() > 0) check("out_len", 64'(out_len), 64'(exp_len_q.pop_front()));
      end
      if (out_clear) begin
        clr_cnt++;
        last_clear_cyc = cyc;
        check("clear_without_payload", 64'(out_valid), 64'd0);
      end
      if (frame_err) err_seen++;
      if (!in_ready) ready_low++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_bytes = 2'd0;
    in_data = 32'h0; hdr_len = 8'h0;
    repeat (3) @(negedge clk);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_flags", 64'({out_valid, out_last, out_clear, out_done, frame_err}), 64'd0);
    check("rst_out_len", 64'(out_len), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    n_rst = 1'b1;
    idle(2);

    // hdr 14 (k=2), 24 bytes, ends with a FLUSH word
    snap();
    send_frame(14, 24, 8'h00, -1, -1);
    idle(4);
    check("t1_clear_at_sop_plus1", 64'(last_clear_cyc), 64'(sop_cyc + 1));
    check("t1_w0", 64'(obs_at(s_obs)), 64'h0_0E0F_1011);
    check("t1_w1", 64'(obs_at(s_obs + 1)), 64'h0_1213_1415);
    check("t1_w2_last", 64'(obs_at(s_obs + 2)), 64'h1_1617_0000);
    check("t1_len", 64'(len_at(s_len)), 64'd10);
    check("t1_flush_ready_low", 64'(ready_low - s_rdy), 64'd1);

    // hdr 16 (k=0), frame ends in first payload word with 3 bytes
    snap();
    send_frame(16, 19, 8'h00, -1, -1);
    idle(4);
    check("t2_word", 64'(obs_at(s_obs)), 64'h1_1011_1200);
    check("t2_len", 64'(len_at(s_len)), 64'd3);
    check("t2_latency", 64'(obs_cyc_at(s_obs) - eop_cyc), 64'd1);

    // hdr 20, frame shorter than header
    snap();
    send_frame(20, 12, 8'h30, -1, -1);
    idle(4);
    check("t3_done", 64'(done_cnt - s_done), 64'd1);
    check("t3_no_valid", 64'(obs_q.size() - s_obs), 64'd0);
    check("t3_len0", 64'(len_at(s_len)), 64'd0);
    check("t3_no_err", 64'(err_seen - s_err), 64'd0);

    // in_valid gap during payload, then a clean frame
    snap();
    send_frame(14, 24, 8'h00, 5, -1);
    idle(4);
    check("t4_words_before_gap", 64'(obs_q.size() - s_obs), 64'd1);
    check("t4_w0", 64'(obs_at(s_obs)), 64'h0_0E0F_1011);
    check("t4_err_pulse", 64'(err_seen - s_err), 64'd1);
    check("t4_no_done", 64'(done_cnt - s_done), 64'd0);
    check("t4_clears", 64'(clr_cnt - s_clr), 64'd2);
    snap();
    send_frame(14, 24, 8'h40, -1, -1);
    idle(4);
    check("t4b_w0", 64'(obs_at(s_obs)), 64'h0_4E4F_5051);
    check("t4b_len", 64'(len_at(s_len)), 64'd10);

    // back-to-back frames, hdr 12
    snap();
    send_frame(12, 20, 8'h80, -1, -1);
    send_frame(12, 18, 8'hA0, -1, -1);
    idle(4);
    check("t5_a_w0", 64'(obs_at(s_obs)), 64'h0_8C8D_8E8F);
    check("t5_a_w1", 64'(obs_at(s_obs + 1)), 64'h1_9091_9293);
    check("t5_b_w0", 64'(obs_at(s_obs + 2)), 64'h0_ACAD_AEAF);
    check("t5_b_w1", 64'(obs_at(s_obs + 3)), 64'h1_B0B1_0000);
    check("t5_a_len", 64'(len_at(s_len)), 64'd8);
    check("t5_b_len", 64'(len_at(s_len + 1)), 64'd6);
    check("t5_clear_between",
          64'((last_clear_cyc > obs_cyc_at(s_obs + 1)) && (last_clear_cyc < obs_cyc_at(s_obs + 2))),
          64'd1);

    // asynchronous reset mid-payload
    send_frame(4, 40, 8'h20, -1, 6);
    @(posedge clk);
    #2 n_rst = 1'b0;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    #1;
    check("rst_mid_out_data", 64'(out_data), 64'd0);
    check("rst_mid_out_flags", 64'({out_valid, out_last, out_clear, out_done, frame_err}), 64'd0);
    check("rst_mid_out_len", 64'(out_len), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    exp_len_q.delete();
    repeat (2) @(negedge clk);
`ifdef PAYLOAD_ALIGNER_STATS_EN
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
    n_rst = 1'b1;
    idle(2);
    snap();
    send_frame(2, 11, 8'h50, -1, -1);
    idle(4);
    check("t6_w0", 64'(obs_at(s_obs)), 64'h0_5455_5657);
    check("t6_w1", 64'(obs_at(s_obs + 1)), 64'h1_5859_5A00);
    check("t6_len", 64'(len_at(s_len)), 64'd7);
`ifdef PAYLOAD_ALIGNER_STATS_EN
    check("t6_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t6_err_cnt", 64'(err_cnt), 64'd0);
`endif

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("exp_len_q_drained", 64'(exp_len_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
